// File: rtl/alu_issue_stage.sv
// ALU issue stage: request FIFO feeding an external combinational ALU, with a registered result slot.
// Optional sticky overflow/carry flags are built when ALU_ISSUE_STICKY_FLAGS_EN is defined.
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [4:0]                 in_opcode,
    output logic [31:0]                alu_a,
    output logic [31:0]                alu_b,
    output logic [4:0]                 alu_opcode,
    input  logic [31:0]                alu_result,
    input  logic                       alu_zero,
    input  logic                       alu_negative,
    input  logic                       alu_carry_out,
    input  logic                       alu_overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [3:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     occupancy,
    input  logic                       flags_clr,
    output logic                       sticky_ovf,
    output logic                       sticky_carry
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    logic [31:0]   mem_a_r  [DEPTH];
    logic [31:0]   mem_b_r  [DEPTH];
    logic [4:0]    mem_op_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          out_valid_r;
    logic [31:0]   out_result_r;
    logic [3:0]    out_flags_r;
    logic          push_s;
    logic          load_s;
    logic          not_empty_s;

    // in_ready looks only at registered occupancy, so a same-cycle pop never frees a slot early
    assign in_ready    = (count_r < CNT_FULL);
    assign not_empty_s = (count_r != '0);
    assign push_s      = in_valid && in_ready;
    assign load_s      = not_empty_s && (!out_valid_r || out_ready);

    assign occupancy  = count_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_flags  = out_flags_r;

    // Present FIFO head to the ALU, or zeros when empty
    always_comb begin
        alu_a      = 32'h0000_0000;
        alu_b      = 32'h0000_0000;
        alu_opcode = 5'd0;
        if (not_empty_s) begin
            alu_a      = mem_a_r[rd_ptr_r];
            alu_b      = mem_b_r[rd_ptr_r];
            alu_opcode = mem_op_r[rd_ptr_r];
        end else begin
            alu_a      = 32'h0000_0000;
            alu_b      = 32'h0000_0000;
            alu_opcode = 5'd0;
        end
    end

    // FIFO storage; contents are don't-care until pointed at, so no reset needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r]  <= in_a;
            mem_b_r[wr_ptr_r]  <= in_b;
            mem_op_r[wr_ptr_r] <= in_opcode;
        end
    end

    // FIFO pointers, occupancy and the result register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            out_valid_r  <= 1'b0;
            out_result_r <= 32'h0000_0000;
            out_flags_r  <= 4'b0000;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (load_s) begin
                rd_ptr_r     <= rd_ptr_r + PTR_ONE;
                out_valid_r  <= 1'b1;
                out_result_r <= alu_result;
                out_flags_r  <= {alu_overflow, alu_carry_out, alu_negative, alu_zero};
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            case ({push_s, load_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    logic sticky_ovf_r;
    logic sticky_carry_r;

    // Accumulate loaded flags; a clear on the same edge as a load keeps only the new flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf_r   <= 1'b0;
            sticky_carry_r <= 1'b0;
        end else if (load_s) begin
            sticky_ovf_r   <= alu_overflow  | (sticky_ovf_r   & ~flags_clr);
            sticky_carry_r <= alu_carry_out | (sticky_carry_r & ~flags_clr);
        end else if (flags_clr) begin
            sticky_ovf_r   <= 1'b0;
            sticky_carry_r <= 1'b0;
        end
    end

    assign sticky_ovf   = sticky_ovf_r;
    assign sticky_carry = sticky_carry_r;
`else
    logic unused_flags_clr_s;
    assign unused_flags_clr_s = flags_clr;
    assign sticky_ovf         = 1'b0;
    assign sticky_carry       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; includes a small reference ALU model.
module tb_alu_issue_stage;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_PASS = 5'd3;

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_negative;
    logic        alu_carry_out;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [2:0]  occupancy;
    logic        flags_clr;
    logic        sticky_ovf;
    logic        sticky_carry;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .occupancy(occupancy),
        .flags_clr(flags_clr), .sticky_ovf(sticky_ovf), .sticky_carry(sticky_carry)
    );

    // Reference combinational ALU driven by the stage
    logic [32:0] wide_s;
    always_comb begin
        wide_s        = 33'd0;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        case (alu_opcode)
            ALU_ADD: begin
                wide_s        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_carry_out = wide_s[32];
                alu_overflow  = (alu_a[31] == alu_b[31]) && (wide_s[31] != alu_a[31]);
            end
            ALU_SUB: begin
                wide_s        = {1'b0, alu_a} - {1'b0, alu_b};
                alu_carry_out = (alu_a >= alu_b);
                alu_overflow  = (alu_a[31] != alu_b[31]) && (wide_s[31] != alu_a[31]);
            end
            ALU_AND:  wide_s = {1'b0, alu_a & alu_b};
            ALU_PASS: wide_s = {1'b0, alu_a};
            default:  wide_s = 33'd0;
        endcase
        alu_result   = wide_s[31:0];
        alu_zero     = (wide_s[31:0] == 32'd0);
        alu_negative = wide_s[31];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 2 time units before any check or drive
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; flags_clr = 1'b0;
        drive(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick(); tick();
        rst = 1'b0;
        check("rst_occ",       {29'd0, occupancy}, 32'd0);
        check("rst_valid",     {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check("rst_result",    out_result, 32'd0);
        check("rst_flags",     {28'd0, out_flags}, 32'd0);
        check("rst_alu_a",     alu_a, 32'd0);
        check("rst_sticky",    {30'd0, sticky_ovf, sticky_carry}, 32'd0);

        // Single add with carry out, zero result
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
        tick();
        drive(1'b0, 32'd0, 32'd0, ALU_ADD);
        check("add_edge1_valid", {31'd0, out_valid}, 32'd0);
        check("add_edge1_occ",   {29'd0, occupancy}, 32'd1);
        check("add_head_a",      alu_a, 32'hFFFF_FFFF);
        tick();
        check("add_valid",  {31'd0, out_valid}, 32'd1);
        check("add_result", out_result, 32'd0);
        check("add_flags",  {28'd0, out_flags}, 32'h5);
        check("add_occ",    {29'd0, occupancy}, 32'd0);
        tick();
        check("add_retire", {31'd0, out_valid}, 32'd0);

        // Backpressure: five PASS requests, one in the result slot and four queued
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i), 32'd0, ALU_PASS);
            tick();
        end
        check("bp_occ_full",  {29'd0, occupancy}, 32'd4);
        check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
        check("bp_valid",     {31'd0, out_valid}, 32'd1);
        check("bp_hold",      out_result, 32'd1);
        drive(1'b1, 32'd99, 32'd0, ALU_PASS);
        tick();
        drive(1'b0, 32'd0, 32'd0, ALU_PASS);
        check("bp_drop_occ",  {29'd0, occupancy}, 32'd4);
        check("bp_hold2",     out_result, 32'd1);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("bp_order_valid", {31'd0, out_valid}, 32'd1);
            check("bp_order",       out_result, 32'(k));
            check("bp_occ_drain",   {29'd0, occupancy}, 32'(5 - k));
            check("bp_ready_again", {31'd0, in_ready}, 32'd1);
        end
        tick();
        check("bp_retire", {31'd0, out_valid}, 32'd0);

        // Streaming SUB requests at full rate
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i), 32'd1, ALU_SUB);
            tick();
            check("st_occ_le1", {31'd0, (occupancy <= 3'd1)}, 32'd1);
            if (i >= 1) begin
                check("st_valid",  {31'd0, out_valid}, 32'd1);
                check("st_result", out_result, 32'(i - 2));
            end
        end
        drive(1'b0, 32'd0, 32'd0, ALU_SUB);
        tick();
        check("st_last_valid",  {31'd0, out_valid}, 32'd1);
        check("st_last_result", out_result, 32'd14);
        tick();
        check("st_retire", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream with a push pending on the reset edge
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(10 + i), 32'd0, ALU_PASS);
            tick();
        end
        check("mr_pre_occ",   {29'd0, occupancy}, 32'd3);
        check("mr_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, ALU_PASS);
        check("mr_occ",      {29'd0, occupancy}, 32'd0);
        check("mr_valid",    {31'd0, out_valid}, 32'd0);
        check("mr_result",   out_result, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("mr_no_flight", {31'd0, out_valid}, 32'd0);

        // Sticky flags: overflowing add, then ANDs, then clear, then clear on a loading edge
        drive(1'b1, 32'h7FFF_FFFF, 32'd1, ALU_ADD);
        tick();
        drive(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        check("sk_ovf_result", out_result, 32'h8000_0000);
        check("sk_ovf_flags",  {28'd0, out_flags}, 32'hA);
        check("sk_ovf_set",    {31'd0, sticky_ovf}, {31'd0, STICKY_ON});
        check("sk_carry_clr",  {31'd0, sticky_carry}, 32'd0);
        drive(1'b1, 32'h0000_00F0, 32'h0000_003C, ALU_AND);
        tick();
        drive(1'b0, 32'd0, 32'd0, ALU_AND);
        tick();
        check("sk_and_result", out_result, 32'h30);
        check("sk_ovf_persist", {31'd0, sticky_ovf}, {31'd0, STICKY_ON});
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("sk_cleared", {31'd0, sticky_ovf}, 32'd0);
        drive(1'b1, 32'h7FFF_FFFF, 32'd1, ALU_ADD);
        tick();
        drive(1'b0, 32'd0, 32'd0, ALU_ADD);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("sk_same_edge", {31'd0, sticky_ovf}, {31'd0, STICKY_ON});
        drive(1'b1, 32'hFFFF_FFFF, 32'd2, ALU_ADD);
        tick();
        drive(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        check("sk_carry_result", out_result, 32'd1);
        check("sk_carry_set",    {31'd0, sticky_carry}, {31'd0, STICKY_ON});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
